// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man mover: direction codes, screen and
// sprite geometry, and the evaluation FSM state encoding.
package pacman_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;

   localparam int SPRITE_PX = 16;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRQ_A  = 3'd1,
      ST_PRQ_B  = 3'd2,
      ST_PCU_A  = 3'd3,
      ST_PCU_B  = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

endpackage

// File: rtl/pacman_corner.sv
// Combinational leading-corner calculator.
// Ports:
//   pos_x/pos_y   current sprite top-left position
//   dir           direction being probed
//   corner_sel    0 = first leading corner, 1 = second leading corner
//   probe_x/y     corner coordinate (low bits of the signed result)
//   out_of_range  corner lies off screen (negative, x>639 or y>479)
module pacman_corner
   import pacman_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic [9:0] pos_x,
   input  logic [8:0] pos_y,
   input  logic [1:0] dir,
   input  logic       corner_sel,
   output logic [9:0] probe_x,
   output logic [8:0] probe_y,
   output logic       out_of_range
);

   localparam logic signed [10:0] STEP_S = 11'(STEP);
   localparam logic signed [10:0] EDGE_S = 11'(SPRITE_PX - 1);
   localparam logic signed [10:0] MAX_X  = 11'(SCREEN_W - 1);
   localparam logic signed [10:0] MAX_Y  = 11'(SCREEN_H - 1);

   logic signed [10:0] x_s, y_s, off_s, px, py;

   always_comb begin
      x_s   = signed'({1'b0, pos_x});
      y_s   = signed'({2'b00, pos_y});
      off_s = corner_sel ? EDGE_S : 11'sd0;
      px    = x_s;
      py    = y_s;
      case (dir)
         DIR_UP:    begin px = x_s + off_s;           py = y_s - STEP_S;          end
         DIR_DOWN:  begin px = x_s + off_s;           py = y_s + EDGE_S + STEP_S; end
         DIR_LEFT:  begin px = x_s - STEP_S;          py = y_s + off_s;           end
         default:   begin px = x_s + EDGE_S + STEP_S; py = y_s + off_s;           end
      endcase
      out_of_range = (px < 11'sd0) || (px > MAX_X) || (py < 11'sd0) || (py > MAX_Y);
      probe_x      = px[9:0];
      probe_y      = py[8:0];
   end

endmodule

// File: rtl/pacman_mover.sv
// Pac-Man sprite mover. Buffers the requested direction and, on each move
// tick, probes the two leading corners of the requested direction against
// the wall map (one corner per cycle); if blocked, falls back to probing the
// current direction, then commits at most one STEP move.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   tick                 1-cycle move strobe (dropped while busy)
//   dir_valid, dir_req   requested direction load
//   map_x, map_y         registered probe coordinate for the map query
//   map_wall             wall bit for (map_x, map_y), same cycle
//   pos_x, pos_y         sprite position
//   cur_dir              direction of the last successful move
//   moving               last evaluation moved the sprite
//   busy                 evaluation in progress
module pacman_mover
   import pacman_pkg::*;
#(
   parameter int STEP    = 2,
   parameter int START_X = 16,
   parameter int START_Y = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       dir_valid,
   input  logic [1:0] dir_req,
   output logic [9:0] map_x,
   output logic [8:0] map_y,
   input  logic       map_wall,
   output logic [9:0] pos_x,
   output logic [8:0] pos_y,
   output logic [1:0] cur_dir,
   output logic       moving,
   output logic       busy
);

   state_t     state_q, state_d;
   logic [1:0] req_dir_q, req_dir_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] cur_dir_q, cur_dir_d;
   logic [1:0] cdir_q, cdir_d;
   logic [9:0] pos_x_q, pos_x_d;
   logic [8:0] pos_y_q, pos_y_d;
   logic [9:0] map_x_q, map_x_d;
   logic [8:0] map_y_q, map_y_d;
   logic       moving_q, moving_d;
   logic       oor_q, oor_d;
   logic       blk_q, blk_d;
   logic       ok_q, ok_d;

   logic       blocked_now;
   logic       probing;
   logic [1:0] c_dir;
   logic       c_sel;
   logic [9:0] c_x;
   logic [8:0] c_y;
   logic       c_oor;

   // An off-screen corner counts as a wall regardless of what the map returns.
   assign blocked_now = oor_q | map_wall;

   always_comb begin
      state_d   = state_q;
      req_dir_d = req_dir_q;
      sel_d     = sel_q;
      cur_dir_d = cur_dir_q;
      cdir_d    = cdir_q;
      pos_x_d   = pos_x_q;
      pos_y_d   = pos_y_q;
      moving_d  = moving_q;
      blk_d     = blk_q;
      ok_d      = ok_q;

      if (dir_valid) req_dir_d = dir_req;

      case (state_q)
         ST_IDLE: begin
            if (tick) begin
               sel_d   = req_dir_q;
               state_d = ST_PRQ_A;
            end
         end
         ST_PRQ_A: begin
            blk_d   = blocked_now;
            state_d = ST_PRQ_B;
         end
         ST_PRQ_B: begin
            if (!(blk_q || blocked_now)) begin
               ok_d    = 1'b1;
               cdir_d  = sel_q;
               state_d = ST_COMMIT;
            end else if (sel_q == cur_dir_q) begin
               // Fallback would re-probe the same corners; skip it.
               ok_d    = 1'b0;
               state_d = ST_COMMIT;
            end else begin
               state_d = ST_PCU_A;
            end
         end
         ST_PCU_A: begin
            blk_d   = blocked_now;
            state_d = ST_PCU_B;
         end
         ST_PCU_B: begin
            ok_d    = !(blk_q || blocked_now);
            cdir_d  = cur_dir_q;
            state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            moving_d = ok_q;
            if (ok_q) begin
               cur_dir_d = cdir_q;
               case (cdir_q)
                  DIR_UP:   pos_y_d = pos_y_q - 9'(STEP);
                  DIR_DOWN: pos_y_d = pos_y_q + 9'(STEP);
                  DIR_LEFT: pos_x_d = pos_x_q - 10'(STEP);
                  default:  pos_x_d = pos_x_q + 10'(STEP);
               endcase
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The probe register is loaded with the corner belonging to the state being
   // entered, so it is stable for the whole probe cycle.
   always_comb begin
      probing = (state_d == ST_PRQ_A) || (state_d == ST_PRQ_B) ||
                (state_d == ST_PCU_A) || (state_d == ST_PCU_B);
      c_dir   = ((state_d == ST_PRQ_A) || (state_d == ST_PRQ_B)) ? sel_d : cur_dir_q;
      c_sel   = (state_d == ST_PRQ_B) || (state_d == ST_PCU_B);
   end

   pacman_corner #(.STEP(STEP)) u_corner (
      .pos_x        (pos_x_q),
      .pos_y        (pos_y_q),
      .dir          (c_dir),
      .corner_sel   (c_sel),
      .probe_x      (c_x),
      .probe_y      (c_y),
      .out_of_range (c_oor)
   );

   always_comb begin
      map_x_d = '0;
      map_y_d = '0;
      oor_d   = 1'b0;
      if (probing) begin
         oor_d = c_oor;
         if (!c_oor) begin
            map_x_d = c_x;
            map_y_d = c_y;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         req_dir_q <= DIR_RIGHT;
         sel_q     <= DIR_RIGHT;
         cur_dir_q <= DIR_RIGHT;
         cdir_q    <= DIR_RIGHT;
         pos_x_q   <= 10'(START_X);
         pos_y_q   <= 9'(START_Y);
         map_x_q   <= '0;
         map_y_q   <= '0;
         moving_q  <= 1'b0;
         oor_q     <= 1'b0;
         blk_q     <= 1'b0;
         ok_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_dir_q <= req_dir_d;
         sel_q     <= sel_d;
         cur_dir_q <= cur_dir_d;
         cdir_q    <= cdir_d;
         pos_x_q   <= pos_x_d;
         pos_y_q   <= pos_y_d;
         map_x_q   <= map_x_d;
         map_y_q   <= map_y_d;
         moving_q  <= moving_d;
         oor_q     <= oor_d;
         blk_q     <= blk_d;
         ok_q      <= ok_d;
      end
   end

   assign map_x   = map_x_q;
   assign map_y   = map_y_q;
   assign pos_x   = pos_x_q;
   assign pos_y   = pos_y_q;
   assign cur_dir = cur_dir_q;
   assign moving  = moving_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover. Unit 0 uses default start (16,16) over a map with
// a wall border and one extra wall cell (col 10, row 1). Unit 1 starts at
// (0,16) over a solid wall map.
module tb_pacman_mover;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       tick_a = 0, dv_a = 0, tick_b = 0, dv_b = 0;
   logic [1:0] dr_a = 0, dr_b = 0;
   logic [9:0] mx_a, mx_b, px_a, px_b;
   logic [8:0] my_a, my_b, py_a, py_b;
   logic       wall_a, wall_b;
   logic [1:0] cd_a, cd_b;
   logic       mv_a, mv_b, bz_a, bz_b;

   function automatic logic map_a(input logic [9:0] x, input logic [8:0] y);
      int cx, cy;
      cx = int'(x) / 16;
      cy = int'(y) / 16;
      return (cy == 0) || (cy == 29) || (cx == 0) || (cx == 39) || (cx == 10 && cy == 1);
   endfunction

   assign wall_a = map_a(mx_a, my_a);
   assign wall_b = 1'b1;

   pacman_mover u_a (
      .clk(clk), .rst_n(rst_n), .tick(tick_a), .dir_valid(dv_a), .dir_req(dr_a),
      .map_x(mx_a), .map_y(my_a), .map_wall(wall_a), .pos_x(px_a), .pos_y(py_a),
      .cur_dir(cd_a), .moving(mv_a), .busy(bz_a)
   );

   pacman_mover #(.STEP(2), .START_X(0), .START_Y(16)) u_b (
      .clk(clk), .rst_n(rst_n), .tick(tick_b), .dir_valid(dv_b), .dir_req(dr_b),
      .map_x(mx_b), .map_y(my_b), .map_wall(wall_b), .pos_x(px_b), .pos_y(py_b),
      .cur_dir(cd_b), .moving(mv_b), .busy(bz_b)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   function automatic logic busy_of(input int u);
      return (u == 0) ? bz_a : bz_b;
   endfunction

   task automatic set_dir(input int u, input logic [1:0] d);
      @(negedge clk);
      if (u == 0) begin dv_a = 1; dr_a = d; end
      else        begin dv_b = 1; dr_b = d; end
      @(negedge clk);
      dv_a = 0; dv_b = 0;
   endtask

   task automatic pulse_tick(input int u);
      if (u == 0) tick_a = 1; else tick_b = 1;
      @(negedge clk);
      tick_a = 0; tick_b = 0;
   endtask

   // Returns number of sampled cycles with busy high after the tick edge.
   task automatic wait_idle(input int u, output int bc);
      bc = 0;
      while (busy_of(u) && bc < 20) begin
         bc++;
         @(negedge clk);
      end
   endtask

   task automatic move(input int u, input logic [1:0] d, output int bc);
      set_dir(u, d);
      pulse_tick(u);
      wait_idle(u, bc);
   endtask

   typedef struct {
      int         unit;
      logic [1:0] dir;
      int         ex, ey, ecur, emv, ebusy;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int bc;
      int rx, ry, rc, rm;

      vecs[0] = '{0, 2'b00, 20, 16, 3, 1, 5};   // up blocked by top row, fall back right
      vecs[1] = '{0, 2'b01, 20, 18, 1, 1, 3};   // down clear
      vecs[2] = '{0, 2'b10, 18, 18, 2, 1, 3};   // left clear
      vecs[3] = '{0, 2'b10, 16, 18, 2, 1, 3};   // left clear
      vecs[4] = '{0, 2'b10, 16, 18, 2, 0, 3};   // left into col 0, same as cur -> no fallback
      vecs[5] = '{0, 2'b00, 16, 16, 0, 1, 3};   // up clear
      vecs[6] = '{0, 2'b00, 16, 16, 0, 0, 3};   // up into top row, same as cur
      vecs[7] = '{0, 2'b11, 18, 16, 3, 1, 3};   // right clear
      vecs[8] = '{1, 2'b10, 0, 16, 3, 0, 5};    // off-screen left, fallback right hits wall
      vecs[9] = '{1, 2'b11, 0, 16, 3, 0, 3};    // right blocked, same as cur

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pos_x", int'(px_a), 16);
      chk("rst_pos_y", int'(py_a), 16);
      chk("rst_cur_dir", int'(cd_a), 3);
      chk("rst_moving", int'(mv_a), 0);
      chk("rst_busy", int'(bz_a), 0);
      chk("rst_map_x", int'(mx_a), 0);
      chk("rst_map_y", int'(my_a), 0);
      chk("rst_b_pos_x", int'(px_b), 0);
      rst_n = 1;

      // Free move right with probe coordinates
      set_dir(0, 2'b11);
      pulse_tick(0);
      chk("prq_a_x", int'(mx_a), 33);
      chk("prq_a_y", int'(my_a), 16);
      chk("prq_a_pos_hold", int'(px_a), 16);
      @(negedge clk);
      chk("prq_b_x", int'(mx_a), 33);
      chk("prq_b_y", int'(my_a), 31);
      @(negedge clk);
      chk("commit_busy", int'(bz_a), 1);
      chk("commit_pos_hold", int'(px_a), 16);
      @(negedge clk);
      chk("free_pos_x", int'(px_a), 18);
      chk("free_pos_y", int'(py_a), 16);
      chk("free_moving", int'(mv_a), 1);
      chk("free_busy", int'(bz_a), 0);

      // Table-driven moves
      for (int i = 0; i < 10; i++) begin
         move(vecs[i].unit, vecs[i].dir, bc);
         rx = (vecs[i].unit == 0) ? int'(px_a) : int'(px_b);
         ry = (vecs[i].unit == 0) ? int'(py_a) : int'(py_b);
         rc = (vecs[i].unit == 0) ? int'(cd_a) : int'(cd_b);
         rm = (vecs[i].unit == 0) ? int'(mv_a) : int'(mv_b);
         chk($sformatf("vec%0d_pos_x", i), rx, vecs[i].ex);
         chk($sformatf("vec%0d_pos_y", i), ry, vecs[i].ey);
         chk($sformatf("vec%0d_cur_dir", i), rc, vecs[i].ecur);
         chk($sformatf("vec%0d_moving", i), rm, vecs[i].emv);
         chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].ebusy);
      end

      // Walk right to x=142, then into the wall at column 10
      for (int i = 0; i < 62; i++) move(0, 2'b11, bc);
      chk("walk_pos_x", int'(px_a), 142);
      move(0, 2'b11, bc);
      chk("wall1_pos_x", int'(px_a), 144);
      chk("wall1_moving", int'(mv_a), 1);
      move(0, 2'b11, bc);
      chk("wall2_pos_x", int'(px_a), 144);
      chk("wall2_pos_y", int'(py_a), 16);
      chk("wall2_moving", int'(mv_a), 0);
      chk("wall2_busy_cycles", bc, 3);

      // Tick while busy is dropped
      set_dir(0, 2'b01);
      pulse_tick(0);
      tick_a = 1;
      @(negedge clk);
      tick_a = 0;
      wait_idle(0, bc);
      repeat (6) @(negedge clk);
      chk("drop_pos_y", int'(py_a), 18);
      chk("drop_pos_x", int'(px_a), 144);
      chk("drop_busy", int'(bz_a), 0);
      chk("drop_cur_dir", int'(cd_a), 1);

      // Reset during PRQ_B
      set_dir(0, 2'b00);
      pulse_tick(0);
      @(posedge clk);
      #1 rst_n = 0;
      #1;
      chk("midrst_pos_x", int'(px_a), 16);
      chk("midrst_pos_y", int'(py_a), 16);
      chk("midrst_busy", int'(bz_a), 0);
      chk("midrst_cur_dir", int'(cd_a), 3);
      chk("midrst_moving", int'(mv_a), 0);
      chk("midrst_map_x", int'(mx_a), 0);
      @(negedge clk);
      rst_n = 1;
      repeat (5) @(negedge clk);
      chk("postrst_pos_x", int'(px_a), 16);
      chk("postrst_pos_y", int'(py_a), 16);
      chk("postrst_busy", int'(bz_a), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
